keycode_event: RTL and testbench

KEYCODE_EVENT -- requirements
Module: keycode_event

---
 rtl/keycode_event.sv | 186 ++++++++++++++++++
 tb/tb_keycode_event.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_event.sv
// Keyboard front end: glitch-filters the SoC keycode, turns direction keys into
// auto-repeating movement steps behind a valid/ready handshake, and pulses on Enter/Backspace.
module keycode_event #(
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 15000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode,
  output logic       step_valid,
  output logic [1:0] step_dir,
  input  logic       step_ready,
  output logic       confirm_pulse,
  output logic       cancel_pulse,
  output logic       dir_held,
  output logic [1:0] fsm_state
);

  // Handshake: step_valid rises with step_dir and both hold until a cycle with
  // step_valid && step_ready; the step is consumed on that cycle's closing edge.

  localparam logic [23:0] STABLE_C    = 24'(STABLE_CYCLES);
  localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

  localparam logic [7:0] KEY_UP     = 8'h1A;
  localparam logic [7:0] KEY_DOWN   = 8'h16;
  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_ENTER  = 8'h28;
  localparam logic [7:0] KEY_BKSP   = 8'h2A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  k_map;
  logic [7:0]  k_reg_q;
  logic [7:0]  cur_key_q, cur_key_d;
  logic [7:0]  prev_key_q;
  logic [23:0] stab_cnt_q, stab_cnt_d;
  logic [23:0] rpt_cnt_q, rpt_cnt_d;
  logic        step_valid_q, step_valid_d;
  logic [1:0]  step_dir_q, step_dir_d;
  logic        confirm_q, confirm_d;
  logic        cancel_q, cancel_d;
  logic        key_chg;
  logic        cur_is_dir;
  logic        fresh_req;
  logic        rpt_req;
  logic        accept;

  function automatic logic is_dir(input logic [7:0] k);
    return (k == KEY_UP) || (k == KEY_DOWN) || (k == KEY_LEFT) || (k == KEY_RIGHT);
  endfunction

  function automatic logic [1:0] dir_of(input logic [7:0] k);
    logic [1:0] d;
    case (k)
      KEY_DOWN:  d = 2'd1;
      KEY_LEFT:  d = 2'd2;
      KEY_RIGHT: d = 2'd3;
      default:   d = 2'd0;
    endcase
    return d;
  endfunction

  always_comb begin
    case (keycode)
      KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_ENTER, KEY_BKSP: k_map = keycode;
      default: k_map = 8'h00;
    endcase
  end

  // Glitch filter: cur_key follows k_reg only once k_reg has held for STABLE_CYCLES.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    cur_key_d  = cur_key_q;
    if (k_map != k_reg_q) begin
      stab_cnt_d = 24'd0;
    end else if (stab_cnt_q < STABLE_C) begin
      stab_cnt_d = stab_cnt_q + 24'd1;
    end
    if (stab_cnt_q == STABLE_C) begin
      cur_key_d = k_reg_q;
    end
  end

  assign key_chg    = (cur_key_q != prev_key_q);
  assign cur_is_dir = is_dir(cur_key_q);

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    fresh_req = 1'b0;
    rpt_req   = 1'b0;
    case (state_q)
      IDLE: begin
        rpt_cnt_d = 24'd0;
        if (key_chg && cur_is_dir) begin
          fresh_req = 1'b1;
          state_d   = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (key_chg) begin
          rpt_cnt_d = 24'd0;
          if (cur_is_dir) begin
            fresh_req = 1'b1;
            state_d   = DELAY;
          end else begin
            state_d = IDLE;
          end
        end else if ((state_q == DELAY) ? (rpt_cnt_q >= DELAY_LAST)
                                        : (rpt_cnt_q >= PERIOD_LAST)) begin
          rpt_req   = 1'b1;
          rpt_cnt_d = 24'd0;
          state_d   = REPEAT;
        end else if (rpt_cnt_q != 24'hFFFFFF) begin
          rpt_cnt_d = rpt_cnt_q + 24'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = 24'd0;
      end
    endcase
  end

  // Single-entry step slot: fresh presses overwrite, repeats only fill a free slot.
  assign accept = step_valid_q && step_ready;

  always_comb begin
    step_valid_d = step_valid_q;
    step_dir_d   = step_dir_q;
    if (fresh_req) begin
      step_valid_d = 1'b1;
      step_dir_d   = dir_of(cur_key_q);
    end else if (rpt_req && (!step_valid_q || accept)) begin
      step_valid_d = 1'b1;
      step_dir_d   = dir_of(cur_key_q);
    end else if (accept) begin
      step_valid_d = 1'b0;
    end
    confirm_d = key_chg && (cur_key_q == KEY_ENTER);
    cancel_d  = key_chg && (cur_key_q == KEY_BKSP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_reg_q      <= 8'h00;
      cur_key_q    <= 8'h00;
      prev_key_q   <= 8'h00;
      stab_cnt_q   <= 24'd0;
      rpt_cnt_q    <= 24'd0;
      state_q      <= IDLE;
      step_valid_q <= 1'b0;
      step_dir_q   <= 2'd0;
      confirm_q    <= 1'b0;
      cancel_q     <= 1'b0;
    end else begin
      k_reg_q      <= k_map;
      cur_key_q    <= cur_key_d;
      prev_key_q   <= cur_key_q;
      stab_cnt_q   <= stab_cnt_d;
      rpt_cnt_q    <= rpt_cnt_d;
      state_q      <= state_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      confirm_q    <= confirm_d;
      cancel_q     <= cancel_d;
    end
  end

  assign step_valid    = step_valid_q;
  assign step_dir      = step_dir_q;
  assign confirm_pulse = confirm_q;
  assign cancel_pulse  = cancel_q;
  assign dir_held      = (state_q != IDLE);
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_keycode_event.sv
// Bench for keycode_event: directed scenarios plus random key/ready traffic,
// all compared every cycle against a timestamp-based reference model.
module tb_keycode_event;

  localparam int STB = 2;
  localparam int RD  = 10;
  localparam int RP  = 4;

  logic       clk;
  logic       reset;
  logic [7:0] keycode;
  logic       step_valid;
  logic [1:0] step_dir;
  logic       step_ready;
  logic       confirm_pulse;
  logic       cancel_pulse;
  logic       dir_held;
  logic [1:0] fsm_state;

  keycode_event #(
    .STABLE_CYCLES(STB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keycode      (keycode),
    .step_valid   (step_valid),
    .step_dir     (step_dir),
    .step_ready   (step_ready),
    .confirm_pulse(confirm_pulse),
    .cancel_pulse (cancel_pulse),
    .dir_held     (dir_held),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: key history, hold timestamps, one-entry step slot
  logic [7:0] hist[$];
  logic [7:0] m_cur;
  bit         chg_prev;
  bit         m_hold;
  int         m_next;
  int         edge_n;
  bit         m_valid;
  logic [1:0] m_dir;
  bit         m_conf;
  bit         m_canc;
  logic [1:0] exp_q[$];
  logic [1:0] act_q[$];
  int         n_acc_model = 0;
  int         n_acc_dut = 0;
  int         n_conf = 0;
  int         n_canc = 0;
  int         n_acc_seen = 0;

  function automatic logic [7:0] key_map(input logic [7:0] k);
    if (k inside {8'h1A, 8'h16, 8'h04, 8'h07, 8'h28, 8'h2A}) return k;
    return 8'h00;
  endfunction

  function automatic bit key_is_dir(input logic [7:0] k);
    return k inside {8'h1A, 8'h16, 8'h04, 8'h07};
  endfunction

  function automatic logic [1:0] key_dir(input logic [7:0] k);
    if (k == 8'h1A) return 2'd0;
    if (k == 8'h16) return 2'd1;
    if (k == 8'h04) return 2'd2;
    return 2'd3;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cur = 8'h00; chg_prev = 0; m_hold = 0; m_next = 0; edge_n = 0;
    m_valid = 0; m_dir = 2'd0; m_conf = 0; m_canc = 0;
  endtask

  task automatic model_edge();
    bit fresh, rep, acc, stable;
    if (reset) begin
      model_reset();
      return;
    end
    edge_n++;
    acc = m_valid && step_ready;
    if (acc) begin
      exp_q.push_back(m_dir);
      n_acc_model++;
    end
    fresh = 0; rep = 0; m_conf = 0; m_canc = 0;
    if (chg_prev) begin
      m_conf = (m_cur == 8'h28);
      m_canc = (m_cur == 8'h2A);
      if (key_is_dir(m_cur)) begin
        m_hold = 1; fresh = 1; m_next = edge_n + RD;
      end else begin
        m_hold = 0;
      end
    end else if (m_hold && edge_n == m_next) begin
      rep = 1; m_next = edge_n + RP;
    end
    if (fresh || (rep && (!m_valid || acc))) begin
      m_valid = 1; m_dir = key_dir(m_cur);
    end else if (acc) begin
      m_valid = 0;
    end
    chg_prev = 0;
    stable = (hist.size() == STB + 1);
    foreach (hist[i]) if (hist[i] != hist[0]) stable = 0;
    if (stable && hist[0] != m_cur) begin
      m_cur = hist[0];
      chg_prev = 1;
    end
    hist.push_back(key_map(keycode));
    if (hist.size() > STB + 1) void'(hist.pop_front());
  endtask

  // DUT-side acceptance monitor feeding the scoreboard
  always @(posedge clk) begin
    if (!reset && step_valid && step_ready) begin
      act_q.push_back(step_dir);
      n_acc_dut++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (!reset) begin
      check("step_valid", step_valid, m_valid);
      if (m_valid) check("step_dir", step_dir, m_dir);
      check("confirm", confirm_pulse, m_conf);
      check("cancel", cancel_pulse, m_canc);
      check("dir_held", dir_held, m_hold);
      while (exp_q.size() > 0 && act_q.size() > 0)
        check("accept_dir", act_q.pop_front(), exp_q.pop_front());
    end
    if (confirm_pulse) n_conf++;
    if (cancel_pulse) n_canc++;
  endtask

  task automatic drive(input logic [7:0] k, input int n);
    keycode = k;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_valid", step_valid, 0);
    check("rst_held", dir_held, 0);
    model_reset();
    exp_q.delete(); act_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] keys[8] = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h28, 8'h2A, 8'h55};

  initial begin
    reset = 1'b1; keycode = 8'h00; step_ready = 1'b1;
    model_reset();
    #1;
    check("reset_valid", step_valid, 0);
    check("reset_dir", step_dir, 0);
    check("reset_conf", confirm_pulse, 0);
    check("reset_canc", cancel_pulse, 0);
    check("reset_held", dir_held, 0);
    do_reset();
    drive(8'h00, 3);

    // up held: first step at edge 4, repeat at +10, then every 4
    drive(8'h1A, 4);
    check("up_e3_valid", step_valid, 0);
    tick();
    check("up_e4_valid", step_valid, 1);
    check("up_e4_dir", step_dir, 0);
    check("up_e4_held", dir_held, 1);
    drive(8'h1A, 9);
    check("up_e13_valid", step_valid, 0);
    tick();
    check("up_e14_valid", step_valid, 1);
    drive(8'h1A, 3);
    check("up_e17_valid", step_valid, 0);
    tick();
    check("up_e18_valid", step_valid, 1);
    drive(8'h00, 6);
    check("up_rel_held", dir_held, 0);

    // one-cycle glitch rejected
    drive(8'h07, 1);
    drive(8'h00, 8);
    check("glitch_held", dir_held, 0);
    check("glitch_valid", step_valid, 0);

    // backpressure: one step survives, repeats dropped
    step_ready = 1'b0;
    n_acc_seen = n_acc_dut;
    drive(8'h16, 30);
    drive(8'h00, 6);
    check("bp_valid", step_valid, 1);
    check("bp_dir", step_dir, 1);
    step_ready = 1'b1;
    drive(8'h00, 6);
    check("bp_accepts", n_acc_dut - n_acc_seen, 1);
    check("bp_cleared", step_valid, 0);

    // direct change up -> right counts as a fresh press
    drive(8'h1A, 5);
    drive(8'h07, 4);
    check("chg_e8_valid", step_valid, 0);
    tick();
    check("chg_step_valid", step_valid, 1);
    check("chg_step_dir", step_dir, 3);
    drive(8'h07, 20);
    drive(8'h00, 6);

    // confirm / cancel / ignored key
    n_conf = 0; n_canc = 0;
    drive(8'h28, 20); drive(8'h00, 5);
    check("confirm_count", n_conf, 1);
    drive(8'h2A, 20); drive(8'h00, 5);
    check("cancel_count", n_canc, 1);
    drive(8'h55, 20); drive(8'h00, 5);
    check("ignored_count", n_conf + n_canc, 2);

    // reset in REPEAT with a pending step
    step_ready = 1'b0;
    drive(8'h04, 25);
    check("pre_rst_valid", step_valid, 1);
    step_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", step_valid, 0);
    check("async_dir", step_dir, 0);
    check("async_held", dir_held, 0);
    check("async_conf", confirm_pulse | cancel_pulse, 0);
    model_reset();
    exp_q.delete(); act_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(8'h04, 4);
    check("rst_e3_valid", step_valid, 0);
    tick();
    check("rst_e4_valid", step_valid, 1);
    check("rst_e4_dir", step_dir, 2);
    drive(8'h00, 6);

    // random traffic
    for (int s = 0; s < 120; s++) begin
      int sel = $urandom_range(0, 8);
      int len = $urandom_range(1, 25);
      keycode = (sel == 8) ? keys[$urandom_range(1, 4)] : keys[sel];
      if (sel == 8) len = 1;
      for (int i = 0; i < len; i++) begin
        step_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    step_ready = 1'b1;
    drive(8'h00, 8);
    check("accept_total", n_acc_dut, n_acc_model);
    check("scoreboard_left", exp_q.size() + act_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
